// File: rtl/cpu_control_pkg.sv
// Shared definitions for the XMen CPU control path: state encoding, opcode
// fields, legal I-type opcode set and the PC / write-back source encodings.
package cpu_defs;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  localparam logic [3:0] RTYPE     = 4'b0000;
  localparam logic [3:0] MEMJ      = 4'b0100;
  localparam logic [3:0] SHIFT     = 4'b1000;
  localparam logic [3:0] BCOND     = 4'b1100;

  localparam logic [3:0] LOAD_EXT  = 4'b0000;
  localparam logic [3:0] STOR_EXT  = 4'b0100;
  localparam logic [3:0] JAL_EXT   = 4'b1000;
  localparam logic [3:0] JCOND_EXT = 4'b1100;
  localparam logic [3:0] LSH_EXT   = 4'b0100;

  // One bit per op code: ANDI ORI XORI ADDI ADDUI ADDCI SUBI SUBCI CMPI MOVI LUI.
  // 1110 is reserved and therefore undefined.
  localparam logic [15:0] ITYPE_LEGAL = 16'hAEEE;

  localparam logic [1:0] PC_INC  = 2'd0;
  localparam logic [1:0] PC_DISP = 2'd1;
  localparam logic [1:0] PC_REG  = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_PC   = 2'd2;

  function automatic logic is_itype(input logic [3:0] op);
    return ITYPE_LEGAL[op];
  endfunction

endpackage

// File: rtl/cpu_control_cond_eval.sv
// Branch/jump condition evaluator: 4-bit condition code against {C,L,F,Z,N}.
module cond_eval (
  input  logic [3:0] i_cond,
  input  logic [4:0] i_flags,
  output logic       o_taken
);

  logic w_c, w_l, w_f, w_z, w_n;
  assign {w_c, w_l, w_f, w_z, w_n} = i_flags;

  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      4'b0000: o_taken = w_z;
      4'b0001: o_taken = !w_z;
      4'b0010: o_taken = w_c;
      4'b0011: o_taken = !w_c;
      4'b0100: o_taken = w_l;
      4'b0101: o_taken = !w_l;
      4'b0110: o_taken = w_n;
      4'b0111: o_taken = !w_n;
      4'b1000: o_taken = w_f;
      4'b1001: o_taken = !w_f;
      4'b1010: o_taken = !w_l && !w_z;
      4'b1011: o_taken = w_l || w_z;
      4'b1100: o_taken = !w_n && !w_z;
      4'b1101: o_taken = w_n || w_z;
      4'b1110: o_taken = 1'b1;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_control.sv
// Multi-cycle control FSM for the 16-bit XMen CPU: fetch, decode, execute,
// memory access and write-back over a single shared memory port.
module cpu_control
  import cpu_defs::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  input  logic [15:0] ir,
  input  logic [4:0]  flags,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_en,
  output logic        pc_en,
  output logic [1:0]  pc_src,
  output logic [3:0]  alu_op,
  output logic        alu_src_imm,
  output logic [7:0]  ext_opcode,
  output logic [3:0]  ext_immlow,
  output logic        flags_en,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        illegal
);

  state_t     r_state, w_next;
  logic       r_fetch_busy;
  logic       w_fetch_req;
  logic       w_taken;
  logic [3:0] w_op, w_ext;

  assign w_op       = ir[15:12];
  assign w_ext      = ir[7:4];
  assign ext_opcode = {ir[15:12], ir[7:4]};
  assign ext_immlow = ir[3:0];

  // Once a fetch request is issued it stays up until memory accepts it,
  // even if run drops in the meantime.
  assign w_fetch_req = run || r_fetch_busy;

  cond_eval u_cond_eval (
    .i_cond  (ir[11:8]),
    .i_flags (flags),
    .o_taken (w_taken)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_FETCH;
      r_fetch_busy <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_fetch_busy <= (r_state == ST_FETCH) && w_fetch_req && !mem_ready;
    end
  end

  always_comb begin
    w_next      = r_state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    ir_en       = 1'b0;
    pc_en       = 1'b0;
    pc_src      = PC_INC;
    alu_op      = 4'd0;
    alu_src_imm = 1'b0;
    flags_en    = 1'b0;
    reg_we      = 1'b0;
    wb_sel      = WB_ALU;
    illegal     = 1'b0;

    case (r_state)
      ST_FETCH: begin
        if (w_fetch_req) begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_en  = 1'b1;
            pc_en  = 1'b1;
            pc_src = PC_INC;
            w_next = ST_DECODE;
          end
        end
      end
      ST_DECODE: w_next = ST_EXEC;
      ST_EXEC: begin
        w_next = ST_FETCH;
        if (w_op == RTYPE) begin
          alu_op   = w_ext;
          flags_en = 1'b1;
          w_next   = ST_WB;
        end else if (w_op == SHIFT && w_ext[3:2] == 2'b00) begin
          alu_op      = SHIFT;
          alu_src_imm = 1'b1;
          w_next      = ST_WB;
        end else if (w_op == SHIFT && w_ext == LSH_EXT) begin
          alu_op = SHIFT;
          w_next = ST_WB;
        end else if (w_op == MEMJ && (w_ext == LOAD_EXT || w_ext == STOR_EXT)) begin
          w_next = ST_MEM;
        end else if (w_op == MEMJ && w_ext == JAL_EXT) begin
          reg_we = 1'b1;
          wb_sel = WB_PC;
          pc_en  = 1'b1;
          pc_src = PC_REG;
        end else if (w_op == MEMJ && w_ext == JCOND_EXT) begin
          pc_en  = w_taken;
          pc_src = w_taken ? PC_REG : PC_INC;
        end else if (w_op == BCOND) begin
          pc_en  = w_taken;
          pc_src = w_taken ? PC_DISP : PC_INC;
        end else if (is_itype(w_op)) begin
          alu_op      = w_op;
          alu_src_imm = 1'b1;
          flags_en    = 1'b1;
          w_next      = ST_WB;
        end else if (ILLEGAL_TRAP) begin
          w_next = ST_TRAP;
        end
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (w_ext == STOR_EXT);
        if (mem_ready) w_next = (w_ext == STOR_EXT) ? ST_FETCH : ST_WB;
      end
      ST_WB: begin
        reg_we = 1'b1;
        wb_sel = (w_op == MEMJ && w_ext == LOAD_EXT) ? WB_MEM : WB_ALU;
        w_next = ST_FETCH;
      end
      ST_TRAP: illegal = 1'b1;
      default: w_next = ST_FETCH;
    endcase

    // Reset silences every strobe immediately, including a pending fetch.
    if (!reset_n) begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      addr_sel = 1'b0;
      ir_en    = 1'b0;
      pc_en    = 1'b0;
      pc_src   = PC_INC;
      alu_op   = 4'd0;
      alu_src_imm = 1'b0;
      flags_en = 1'b0;
      reg_we   = 1'b0;
      wb_sel   = WB_ALU;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_control.sv
// Directed bench for cpu_control: ALU, LOAD with wait states, STOR, branches,
// JAL, run handshake, trap and asynchronous reset behaviour.
module tb_cpu_control;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run;
  logic [15:0] ir;
  logic [4:0]  flags;
  logic        mem_ready;
  logic        mem_req, mem_we, addr_sel, ir_en, pc_en;
  logic [1:0]  pc_src, wb_sel;
  logic [3:0]  alu_op, ext_immlow;
  logic        alu_src_imm, flags_en, reg_we, illegal;
  logic [7:0]  ext_opcode;

  int n_checks = 0;
  int n_errors = 0;

  cpu_control #(.ILLEGAL_TRAP(1'b1)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .run         (run),
    .ir          (ir),
    .flags       (flags),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .addr_sel    (addr_sel),
    .ir_en       (ir_en),
    .pc_en       (pc_en),
    .pc_src      (pc_src),
    .alu_op      (alu_op),
    .alu_src_imm (alu_src_imm),
    .ext_opcode  (ext_opcode),
    .ext_immlow  (ext_immlow),
    .flags_en    (flags_en),
    .reg_we      (reg_we),
    .wb_sel      (wb_sel),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; run = 1'b1; mem_ready = 1'b1; ir = 16'h0251; flags = 5'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_ir_en", ir_en, 0);
    chk("rst_pc_en", pc_en, 0);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_ext_opcode", ext_opcode, 8'h05);
    chk("rst_ext_immlow", ext_immlow, 4'h1);

    // ADD R2,R1
    @(negedge clk); reset_n = 1'b1; #1;
    chk("add_c0_mem_req", mem_req, 1);
    chk("add_c0_addr_sel", addr_sel, 0);
    chk("add_c0_ir_en", ir_en, 1);
    chk("add_c0_pc_en", pc_en, 1);
    chk("add_c0_pc_src", pc_src, 0);
    tick();
    chk("add_c1_mem_req", mem_req, 0);
    chk("add_c1_ir_en", ir_en, 0);
    chk("add_c1_reg_we", reg_we, 0);
    tick();
    chk("add_c2_alu_op", alu_op, 4'h5);
    chk("add_c2_src_imm", alu_src_imm, 0);
    chk("add_c2_flags_en", flags_en, 1);
    chk("add_c2_reg_we", reg_we, 0);
    tick();
    chk("add_c3_reg_we", reg_we, 1);
    chk("add_c3_wb_sel", wb_sel, 0);
    chk("add_c3_flags_en", flags_en, 0);
    tick();
    chk("add_c4_mem_req", mem_req, 1);
    chk("add_c4_ir_en", ir_en, 1);

    // LOAD with two wait states in MEM
    ir = 16'h4301;
    tick();
    tick();
    chk("ld_exec_mem_req", mem_req, 0);
    mem_ready = 1'b0;
    tick();
    chk("ld_m1_mem_req", mem_req, 1);
    chk("ld_m1_addr_sel", addr_sel, 1);
    chk("ld_m1_mem_we", mem_we, 0);
    tick();
    chk("ld_m2_mem_req", mem_req, 1);
    chk("ld_m2_addr_sel", addr_sel, 1);
    tick();
    mem_ready = 1'b1; #1;
    chk("ld_m3_mem_req", mem_req, 1);
    chk("ld_m3_addr_sel", addr_sel, 1);
    chk("ld_m3_reg_we", reg_we, 0);
    tick();
    chk("ld_wb_reg_we", reg_we, 1);
    chk("ld_wb_wb_sel", wb_sel, 1);
    chk("ld_wb_mem_req", mem_req, 0);
    tick();
    chk("ld_fetch_ir_en", ir_en, 1);

    // Bcond EQ, Z=1 then Z=0
    ir = 16'hC0FE; flags = 5'b00010;
    tick();
    chk("beq_dec_pc_en", pc_en, 0);
    tick();
    chk("beq_t_pc_en", pc_en, 1);
    chk("beq_t_pc_src", pc_src, 1);
    tick();
    chk("beq_t_fetch", ir_en, 1);
    flags = 5'b00000;
    tick();
    tick();
    chk("beq_nt_pc_en", pc_en, 0);
    tick();
    chk("beq_nt_fetch", ir_en, 1);

    // Bcond LT with N=0,Z=0 is taken
    ir = 16'hCC05; flags = 5'b10000;
    tick();
    tick();
    chk("blt_pc_en", pc_en, 1);
    chk("blt_pc_src", pc_src, 1);
    tick();

    // JAL
    ir = 16'h4E82;
    tick();
    tick();
    chk("jal_reg_we", reg_we, 1);
    chk("jal_wb_sel", wb_sel, 2);
    chk("jal_pc_en", pc_en, 1);
    chk("jal_pc_src", pc_src, 2);
    tick();
    chk("jal_fetch_mem_req", mem_req, 1);
    chk("jal_fetch_reg_we", reg_we, 0);

    // Jcond with never-condition is not taken
    ir = 16'h4FC3;
    tick();
    tick();
    chk("jnv_pc_en", pc_en, 0);
    tick();

    // STOR
    ir = 16'h4341;
    tick();
    tick();
    chk("st_exec_mem_req", mem_req, 0);
    tick();
    chk("st_mem_req", mem_req, 1);
    chk("st_addr_sel", addr_sel, 1);
    chk("st_mem_we", mem_we, 1);
    tick();
    chk("st_fetch_addr_sel", addr_sel, 0);
    chk("st_fetch_mem_we", mem_we, 0);
    chk("st_fetch_reg_we", reg_we, 0);
    chk("st_fetch_ir_en", ir_en, 1);

    // Shift immediate
    ir = 16'h8315;
    tick();
    tick();
    chk("shi_alu_op", alu_op, 4'h8);
    chk("shi_src_imm", alu_src_imm, 1);
    chk("shi_flags_en", flags_en, 0);
    tick();
    chk("shi_wb_reg_we", reg_we, 1);
    tick();

    // I-type SUBCI
    ir = 16'hAB07;
    tick();
    tick();
    chk("imm_alu_op", alu_op, 4'hA);
    chk("imm_src_imm", alu_src_imm, 1);
    chk("imm_flags_en", flags_en, 1);
    tick();
    chk("imm_wb_reg_we", reg_we, 1);
    chk("imm_wb_sel", wb_sel, 0);

    // run handshake in FETCH
    tick();
    run = 1'b0; #1;
    chk("idle_mem_req", mem_req, 0);
    chk("idle_ir_en", ir_en, 0);
    tick();
    chk("idle2_mem_req", mem_req, 0);
    run = 1'b1; mem_ready = 1'b0; #1;
    chk("wait_mem_req", mem_req, 1);
    chk("wait_ir_en", ir_en, 0);
    tick();
    run = 1'b0; #1;
    chk("hold_mem_req", mem_req, 1);
    mem_ready = 1'b1; #1;
    chk("hold_ir_en", ir_en, 1);
    chk("hold_pc_en", pc_en, 1);

    // Undefined op traps and stays there
    ir = 16'hE123;
    tick();
    run = 1'b1;
    tick();
    chk("trap_exec_illegal", illegal, 0);
    tick();
    for (int i = 0; i < 20; i++) begin
      chk("trap_illegal", illegal, 1);
      chk("trap_mem_req", mem_req, 0);
      tick();
    end

    // Reset pulse leaves TRAP
    reset_n = 1'b0; #1;
    chk("trst_illegal", illegal, 0);
    chk("trst_mem_req", mem_req, 0);
    tick();
    run = 1'b0; reset_n = 1'b1; #1;
    chk("post_illegal", illegal, 0);
    chk("post_mem_req", mem_req, 0);
    chk("post_reg_we", reg_we, 0);
    run = 1'b1; mem_ready = 1'b0; #1;
    chk("post_fetch_req", mem_req, 1);

    // Reset mid-request drops mem_req at once
    #2 reset_n = 1'b0; #1;
    chk("midrst_mem_req", mem_req, 0);
    tick();
    reset_n = 1'b1; #1;
    chk("rel_mem_req", mem_req, 1);
    mem_ready = 1'b1; #1;
    chk("rel_ir_en", ir_en, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
